// File: rtl/mux_rr_arbiter_if.sv
// rtl/mux_rr_arbiter_if.sv - valid/ready beat channel with packet delimiter
interface mux_rr_arbiter_if #(
    parameter int DATA_W = 8
);
    logic              valid;
    logic [DATA_W-1:0] data;
    logic              last;
    logic              ready;

    // Producer side of a channel
    modport master (
        output valid,
        output data,
        output last,
        input  ready
    );

    // Consumer side of a channel
    modport slave (
        input  valid,
        input  data,
        input  last,
        output ready
    );
endinterface

// File: rtl/mux_rr_arbiter.sv
// rtl/mux_rr_arbiter.sv - two-requester packet round-robin arbiter driving a 2:1 mux
module mux_rr_arbiter #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    mux_rr_arbiter_if.slave   in0,
    mux_rr_arbiter_if.slave   in1,
    mux_rr_arbiter_if.master  out,
    output logic              sel,
    output logic              busy
);

    typedef enum logic {
        IDLE = 1'b0,
        LOCK = 1'b1
    } state_t;

    state_t            state_q;
    logic              sel_q;
    logic              prio_q;
    logic              busy_q;

    logic              grant_valid;
    logic              grant_last;
    logic [DATA_W-1:0] grant_data;
    logic              xfer_last;

    // Steer the granted requester onto the output; everything is quiet outside LOCK
    always_comb begin
        grant_valid = 1'b0;
        grant_last  = 1'b0;
        grant_data  = '0;
        in0.ready   = 1'b0;
        in1.ready   = 1'b0;
        if (state_q == LOCK) begin
            if (sel_q) begin
                grant_valid = in1.valid;
                grant_last  = in1.last;
                grant_data  = in1.data;
                in1.ready   = out.ready;
            end else begin
                grant_valid = in0.valid;
                grant_last  = in0.last;
                grant_data  = in0.data;
                in0.ready   = out.ready;
            end
        end
        xfer_last = grant_valid & out.ready & grant_last;
    end

    assign out.valid = grant_valid;
    assign out.data  = grant_data;
    assign out.last  = grant_last;
    assign sel       = sel_q;
    assign busy      = busy_q;

    // Grant FSM: pick a requester in IDLE, hold it until the last beat is taken
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            sel_q   <= 1'b0;
            prio_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in0.valid || in1.valid) begin
                        // On a tie the preferred requester wins, otherwise the only one asking
                        sel_q   <= (in0.valid && in1.valid) ? prio_q : in1.valid;
                        state_q <= LOCK;
                        busy_q  <= 1'b1;
                    end
                end
                LOCK: begin
                    if (xfer_last) begin
                        // Hand preference to the requester that just lost out
                        prio_q  <= ~sel_q;
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

endmodule
